// File: rtl/burst_seq_fsm.sv
// Burst sequencer: accepts a start with beat count and channel, steps a beat counter, one-hot grant.
// Latency: first beat 1 cycle after start; N beats then 1 DONE cycle; err/aborted pulses are registered (+1 cycle).
// Backpressure: stall freezes state and count; abort ends the burst immediately; start outside IDLE is dropped with err.
module burst_seq_fsm #(
    parameter int CNT_W  = 4,
    parameter int NUM_CH = 2,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic              stall,
    input  logic              abort,
    output logic [CNT_W-1:0]  count,
    output logic              active,
    output logic              beat,
    output logic [NUM_CH-1:0] ch_grant,
    output logic              done,
    output logic              aborted,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Channel count widened by one bit so the range check works even when NUM_CH is a power of two.
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count_q, count_nxt;
    logic [CNT_W-1:0]  len_q, len_nxt;
    logic [CH_W-1:0]   ch_q, ch_nxt;
    logic              err_q, err_nxt;
    logic              aborted_q, aborted_nxt;
    logic              ch_ok;

    assign ch_ok = ({1'b0, ch_sel} < NUM_CH_L);

    // State and datapath registers; reset has priority over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count_q   <= '0;
            len_q     <= '0;
            ch_q      <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            count_q   <= count_nxt;
            len_q     <= len_nxt;
            ch_q      <= ch_nxt;
            err_q     <= err_nxt;
            aborted_q <= aborted_nxt;
        end
    end

    // Next-state logic: abort beats stall beats beat; start is only honoured in IDLE.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count_q;
        len_nxt     = len_q;
        ch_nxt      = ch_q;
        err_nxt     = 1'b0;
        aborted_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (ch_ok) begin
                        state_nxt = ACTIVE;
                        len_nxt   = len;
                        ch_nxt    = ch_sel;
                        count_nxt = '0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                err_nxt = start;
                if (abort) begin
                    state_nxt   = IDLE;
                    count_nxt   = '0;
                    aborted_nxt = 1'b1;
                end else if (!stall) begin
                    if (count_q == len_q) begin
                        state_nxt = DONE;
                        count_nxt = '0;
                    end else begin
                        count_nxt = count_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                err_nxt   = start;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                count_nxt = '0;
            end
        endcase
    end

    // One-hot grant of the latched channel, only while a burst is active.
    always_comb begin
        ch_grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_grant[i] = active && (ch_q == CH_W'(i));
        end
    end

    assign active  = (state == ACTIVE);
    assign beat    = active && !stall;
    assign done    = (state == DONE);
    assign count   = count_q;
    assign err     = err_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_burst_seq_fsm.sv
// Bench for burst_seq_fsm: two instances (2 and 3 channels) share stimulus from a vector table.
// Each row's expected outputs are queued when the row is driven and compared mid-cycle.
// Rows describe the inputs of one cycle and the outputs visible during that same cycle.
module tb_burst_seq_fsm;

    logic       clk = 1'b0;
    logic       reset, start, stall, abort;
    logic [3:0] len;
    logic       ch_sel2;
    logic [1:0] ch_sel3;

    logic [3:0] count2, count3;
    logic       active2, active3, beat2, beat3;
    logic [1:0] grant2;
    logic [2:0] grant3;
    logic       done2, done3, aborted2, aborted3, err2, err3;

    always #5 clk = ~clk;

    burst_seq_fsm #(.CNT_W(4), .NUM_CH(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .len(len), .ch_sel(ch_sel2),
        .stall(stall), .abort(abort), .count(count2), .active(active2), .beat(beat2),
        .ch_grant(grant2), .done(done2), .aborted(aborted2), .err(err2)
    );

    burst_seq_fsm #(.CNT_W(4), .NUM_CH(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .len(len), .ch_sel(ch_sel3),
        .stall(stall), .abort(abort), .count(count3), .active(active3), .beat(beat3),
        .ch_grant(grant3), .done(done3), .aborted(aborted3), .err(err3)
    );

    typedef struct packed {
        logic [3:0] cnt;
        logic       act;
        logic       bt;
        logic [2:0] gr;
        logic       dn;
        logic       er;
        logic       abd;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       st;
        logic [3:0] ln;
        logic [1:0] ch;
        logic       stl;
        logic       ab;
        logic       d3;
        exp_t       e;
    } vec_t;

    typedef struct {
        int   idx;
        logic d3;
        exp_t e;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic rst, input logic st, input logic [3:0] ln, input logic [1:0] ch,
                       input logic stl, input logic ab, input logic d3,
                       input logic [3:0] cnt, input logic act, input logic bt, input logic [2:0] gr,
                       input logic dn, input logic er, input logic abd);
        vec_t v;
        v.rst = rst; v.st = st; v.ln = ln; v.ch = ch; v.stl = stl; v.ab = ab; v.d3 = d3;
        v.e = '{cnt: cnt, act: act, bt: bt, gr: gr, dn: dn, er: er, abd: abd};
        vecs.push_back(v);
    endtask

    // Checker: pops the expectation for the current cycle, well clear of the rising edge.
    sb_t  cur;
    exp_t got;
    always @(negedge clk) begin
        #2;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.d3)
                got = '{cnt: count3, act: active3, bt: beat3, gr: grant3, dn: done3, er: err3, abd: aborted3};
            else
                got = '{cnt: count2, act: active2, bt: beat2, gr: {1'b0, grant2}, dn: done2, er: err2, abd: aborted2};
            n_checks++;
            if (got !== cur.e) begin
                n_fail++;
                $display("FAIL row %0d (dut%0d): got cnt=%0d active=%b beat=%b grant=%b done=%b err=%b aborted=%b, expected cnt=%0d active=%b beat=%b grant=%b done=%b err=%b aborted=%b",
                         cur.idx, cur.d3 ? 3 : 2, got.cnt, got.act, got.bt, got.gr, got.dn, got.er, got.abd,
                         cur.e.cnt, cur.e.act, cur.e.bt, cur.e.gr, cur.e.dn, cur.e.er, cur.e.abd);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with start asserted: nothing may leak through.
        add(1,1,2,1,0,0,0, 0,0,0,3'b000,0,0,0);
        add(1,1,2,1,0,0,0, 0,0,0,3'b000,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,3'b000,0,0,0);
        // 3-beat burst on channel 1, no stalls.
        add(0,1,2,1,0,0,0, 0,0,0,3'b000,0,0,0);
        add(0,0,0,0,0,0,0, 0,1,1,3'b010,0,0,0);
        add(0,0,0,0,0,0,0, 1,1,1,3'b010,0,0,0);
        add(0,0,0,0,0,0,0, 2,1,1,3'b010,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,3'b000,1,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,3'b000,0,0,0);
        // 4-beat burst on channel 0 with a 2-cycle stall at count 1.
        add(0,1,3,0,0,0,0, 0,0,0,3'b000,0,0,0);
        add(0,0,0,0,0,0,0, 0,1,1,3'b001,0,0,0);
        add(0,0,0,0,1,0,0, 1,1,0,3'b001,0,0,0);
        add(0,0,0,0,1,0,0, 1,1,0,3'b001,0,0,0);
        add(0,0,0,0,0,0,0, 1,1,1,3'b001,0,0,0);
        add(0,0,0,0,0,0,0, 2,1,1,3'b001,0,0,0);
        add(0,0,0,0,0,0,0, 3,1,1,3'b001,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,3'b000,1,0,0);
        // abort and stall in IDLE are ignored.
        add(0,0,0,0,1,1,0, 0,0,0,3'b000,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,3'b000,0,0,0);
        // 8-beat burst aborted at count 4, with a colliding start: both pulses, no done.
        add(0,1,7,1,0,0,0, 0,0,0,3'b000,0,0,0);
        add(0,0,0,0,0,0,0, 0,1,1,3'b010,0,0,0);
        add(0,0,0,0,0,0,0, 1,1,1,3'b010,0,0,0);
        add(0,0,0,0,0,0,0, 2,1,1,3'b010,0,0,0);
        add(0,0,0,0,0,0,0, 3,1,1,3'b010,0,0,0);
        add(0,1,0,0,0,1,0, 4,1,1,3'b010,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,3'b000,0,1,1);
        add(0,0,0,0,0,0,0, 0,0,0,3'b000,0,0,0);
        // Single-beat burst accepted right after the abort.
        add(0,1,0,0,0,0,0, 0,0,0,3'b000,0,0,0);
        add(0,0,0,0,0,0,0, 0,1,1,3'b001,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,3'b000,1,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,3'b000,0,0,0);
        // abort outranks stall on the same cycle.
        add(0,1,1,0,0,0,0, 0,0,0,3'b000,0,0,0);
        add(0,0,0,0,1,1,0, 0,1,0,3'b001,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,3'b000,0,0,1);
        add(0,0,0,0,0,0,0, 0,0,0,3'b000,0,0,0);
        // Maximum burst with start held high: count wraps 15 -> 0 into DONE, dropped starts flag err.
        add(0,1,15,1,0,0,0, 0,0,0,3'b000,0,0,0);
        for (int k = 0; k < 16; k++)
            add(0,1,15,1,0,0,0, 4'(k),1,1,3'b010,0,(k != 0),0);
        add(0,1,1,1,0,0,0, 0,0,0,3'b000,1,1,0);
        add(0,1,1,1,0,0,0, 0,0,0,3'b000,0,1,0);
        add(0,0,0,0,0,0,0, 0,1,1,3'b010,0,0,0);
        add(0,0,0,0,0,0,0, 1,1,1,3'b010,0,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,3'b000,1,0,0);
        add(0,0,0,0,0,0,0, 0,0,0,3'b000,0,0,0);
        // 3-channel instance: top channel is granted, out-of-range channel is rejected.
        add(0,1,1,2,0,0,1, 0,0,0,3'b000,0,0,0);
        add(0,0,0,0,0,0,1, 0,1,1,3'b100,0,0,0);
        add(0,0,0,0,0,0,1, 1,1,1,3'b100,0,0,0);
        add(0,0,0,0,0,0,1, 0,0,0,3'b000,1,0,0);
        add(0,1,1,3,0,0,1, 0,0,0,3'b000,0,0,0);
        add(0,0,0,0,0,0,1, 0,0,0,3'b000,0,1,0);
        add(0,0,0,0,0,0,1, 0,0,0,3'b000,0,0,0);
        // Reset mid-burst discards it without done or aborted.
        add(0,1,3,0,0,0,1, 0,0,0,3'b000,0,0,0);
        add(0,0,0,0,0,0,1, 0,1,1,3'b001,0,0,0);
        add(1,0,0,0,0,0,1, 1,1,1,3'b001,0,0,0);
        add(0,0,0,0,0,0,1, 0,0,0,3'b000,0,0,0);
        add(0,0,0,0,0,0,1, 0,0,0,3'b000,0,0,0);

        // One reset edge before the table so the first row sees defined state.
        reset = 1'b1; start = 1'b1; len = 4'd2; ch_sel2 = 1'b1; ch_sel3 = 2'd1;
        stall = 1'b0; abort = 1'b0;
        @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            sb_t s;
            @(negedge clk);
            reset   = vecs[i].rst;
            start   = vecs[i].st;
            len     = vecs[i].ln;
            ch_sel2 = vecs[i].ch[0];
            ch_sel3 = vecs[i].ch;
            stall   = vecs[i].stl;
            abort   = vecs[i].ab;
            s.idx = i; s.d3 = vecs[i].d3; s.e = vecs[i].e;
            sb.push_back(s);
        end

        @(negedge clk);
        start = 1'b0; stall = 1'b0; abort = 1'b0; reset = 1'b0;
        #5;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_seq_fsm.md
Name: burst_seq_fsm

Overview:
Parametrised burst sequencer for the sparse-matrix write path. It generalises the fixed 3-beat write-enable controller.
- Accepts a start request with a programmable beat count and a target channel.
- Steps a beat counter through the burst, holding while downstream stalls.
- Drives a one-hot channel grant.
- Reports completion, abort and rejected requests as single-cycle pulses.
It sits between the matrix-load front end and the per-channel value/index buffers.

Parameters:
CNT_W, 4, width of burst length and beat counter; maximum burst is 2**CNT_W beats.
NUM_CH, 2, number of destination channels; must be at least 1.
CH_W, $clog2(NUM_CH) (1 when NUM_CH=1), width of the channel select.

Ports:
clk  in  1  clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  burst request; sampled only in IDLE.
len  in  CNT_W  beats minus one (0 = 1 beat); sampled with start.
ch_sel  in  CH_W  destination channel; sampled with start.
stall  in  1  downstream not ready; freezes the current beat.
abort  in  1  terminate the burst in progress.
count  out  CNT_W  index of the current beat within the burst.
active  out  1  high in ACTIVE state.
beat  out  1  active & !stall; one beat is consumed this cycle.
ch_grant  out  NUM_CH  one-hot of the latched channel while active, else 0.
done  out  1  one-cycle pulse after the final beat.
aborted  out  1  one-cycle pulse after an abort.
err  out  1  one-cycle pulse when a request is rejected or dropped.

Behaviour:
- States: IDLE, ACTIVE, DONE.
- Internal registers: len_q (CNT_W bits) and ch_q (CH_W bits).
- Reset, synchronous and taking priority over every other input:
  - state=IDLE; count=0; len_q=0; ch_q=0; err=0; aborted=0.
  - Consequently active=beat=done=0 and ch_grant=0 during and after reset.
  - Reset mid-burst discards the burst with no done or aborted pulse.
- IDLE:
  - start=1 with ch_sel<NUM_CH: latch len_q=len and ch_q=ch_sel, set count=0, enter ACTIVE next cycle.
  - start=1 with ch_sel>=NUM_CH: stay in IDLE, pulse err next cycle, latch nothing.
  - abort and stall are ignored.
- ACTIVE:
  - active=1 and ch_grant[ch_q]=1, both combinational from state.
  - beat = !stall, combinational.
  - Priority order per cycle: abort, then stall, then beat.
  - abort=1: next state IDLE, count=0, aborted=1 next cycle. No done pulse, even if this would have been the last beat.
  - stall=1 and no abort: state and count are held.
  - beat with count<len_q: count increments by 1.
  - beat with count==len_q: count returns to 0 and the next state is DONE.
  - count never exceeds len_q. With len=2**CNT_W-1, count reaches all-ones and then returns to 0 with no overflow.
  - start=1 in ACTIVE is dropped and err pulses next cycle; the burst is unaffected.
- DONE:
  - done=1 for exactly one cycle, then IDLE unconditionally.
  - start in DONE is dropped with an err pulse.
  - The minimum gap between bursts is therefore one DONE cycle plus one IDLE sample cycle.
- Latency:
  - start to first beat: 1 cycle.
  - An N-beat burst with no stalls has active high for N cycles, then done high for 1 cycle.
- Pulse timing:
  - err and aborted are registered, one cycle after the causing event.
  - done is decoded from state.
  - Simultaneous err and aborted (start and abort in the same ACTIVE cycle) are both asserted.
- Outputs are never X after the first reset cycle.

Test Plan:
- Reset held 2 cycles with start=1 -> count=0, active=0, ch_grant=0, done=0, err=0 throughout and after.
- start, len=2, ch_sel=1, no stall (NUM_CH=2) -> active for 3 cycles with count 0,1,2 and ch_grant=2'b10; done high on cycle 4; IDLE on cycle 5.
- len=3 with stall=1 on the cycle count==1 for 2 cycles -> count sequence 0,1,1,1,2,3; beat low on the stalled cycles; done after 6 active cycles.
- len=7 with abort=1 when count==4 -> IDLE next cycle, count=0, aborted pulses once, done never asserts; a new start is then accepted normally.
- start with ch_sel=2 when NUM_CH=3 -> burst proceeds with ch_grant=3'b100. With ch_sel=3 and NUM_CH=3 -> stays in IDLE, err pulses once, active stays 0.
- len=15 (CNT_W=4) back-to-back starts held high -> 16 beats with count wrapping 15 to 0 into DONE; err pulses for every start sampled in ACTIVE/DONE; the second burst begins after the IDLE cycle.
